interleaver_mm: RTL and testbench
=================================

INTERLEAVER_MM -- requirements
Module: interleaver_mm

Interface
REQ-001 SHALL have parameter MAX_NCBPS, default 288, largest block size supported; legal values 48, 96, 192, 288.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on rising clk).
REQ-004 SHALL have port mode, input, 2, rate class: 0=BPSK (NCBPS 48, NBPSC 1), 1=QPSK (96, 2), 2=16QAM (192, 4), 3=64QAM (288, 6).
REQ-005 SHALL have port in_valid, input, 1, input bit qualifier.
REQ-006 SHALL have port in, input, 1, serial coded bit.
REQ-007 SHALL have port in_ready, output, 1, block can accept a bit this cycle.
REQ-008 SHALL have port out_valid, output, 1, out carries a permuted bit.
REQ-009 SHALL have port out, output, 1, serial permuted bit.
REQ-010 SHALL have port out_last, output, 1, high with the final bit of each block.
REQ-011 SHALL have port mode_err, output, 1, one-cycle pulse when a block starts in a mode whose NCBPS exceeds MAX_NCBPS.

Function
REQ-012 SHALL accept a bit only on a rising clk with in_valid=1 and in_ready=1; input index k counts accepted bits 0..NCBPS-1; gaps hold k.
REQ-013 SHALL latch mode when k=0 is accepted; mode changes mid-block SHALL be ignored until the next block.
REQ-014 SHALL compute i=(NCBPS/16)*(k mod 16)+floor(k/16), s=max(NBPSC/2,1), j=s*floor(i/s)+(i+NCBPS-floor(16*i/NCBPS)) mod s.
REQ-015 SHALL write accepted bit k into address j of the current write bank; two MAX_NCBPS-bit ping-pong banks.
REQ-016 SHALL mark the write bank full and swap banks on acceptance of bit k=NCBPS-1.
REQ-017 Read FSM SHALL have states IDLE and READ; IDLE->READ on the cycle after a bank becomes full; READ->IDLE after NCBPS outputs unless the other bank is full, in which case it SHALL stay in READ with no bubble.
REQ-018 In READ, SHALL output addresses 0..NCBPS-1 of the read bank (using that block's latched mode) with out_valid=1 on consecutive cycles, no stalls.
REQ-019 Latency: first out_valid SHALL be 1 cycle after acceptance of the block's last bit when the read side is idle.
REQ-020 SHALL assert out_last with address NCBPS-1 and free the bank the same cycle.
REQ-021 in_ready SHALL be 0 while the write bank is still full (both banks occupied) and 1 otherwise; deasserts only between blocks.
REQ-022 Equal-size back-to-back blocks at full input rate SHALL stream with in_ready permanently 1.
REQ-023 A block whose mode NCBPS exceeds MAX_NCBPS SHALL pulse mode_err at k=0, drop that bit and not start a block.
REQ-024 When out_valid=0, out and out_last SHALL be 0.

Reset
REQ-025 reset=0 SHALL set out=0, out_valid=0, out_last=0, mode_err=0, in_ready=1, k=0, both banks empty, FSM IDLE.
REQ-026 Reset mid-block or mid-read SHALL discard all partial and stored blocks; bank contents need not be cleared.

Configuration
REQ-027 With macro WLAN_DEINTERLEAVE_EN defined, SHALL add input port dir (1 bit, latched with mode); dir=1 writes bit k at address k and reads address j(k) for output k (inverse permutation).
REQ-028 Without WLAN_DEINTERLEAVE_EN, port dir SHALL not exist and behaviour SHALL be interleave only.

Verification
REQ-029 Mode 0, block with only k=1 set -> out_valid run of 48, only output index 3 high; out_last at index 47.
REQ-030 Mode 1 k=1 set -> output index 6 high; mode 2 k=1 -> index 13; mode 3 k=1 -> index 20.
REQ-031 Mode 3 block then mode 0 block at full rate -> in_ready low after mode 0 block completes until mode 3 read emits out_last; both outputs correct.
REQ-032 Reset asserted at k=100 of mode 3 block -> all outputs at reset values next cycle, next block from k=0 correct.
REQ-033 MAX_NCBPS=96, mode 3 start -> mode_err one-cycle pulse, no out_valid.
REQ-034 WLAN_DEINTERLEAVE_EN: interleave random 288-bit block, feed output with dir=1 -> original sequence restored.

Source files
------------

// File: rtl/interleaver_mm.sv
// Block bit interleaver (3/6/12/18-column 802.11a-style permutation) with two ping-pong banks.
// Latency: first out_valid 1 cycle after a block's last accepted bit; in_ready drops only when both banks hold blocks.
// Optional macro WLAN_DEINTERLEAVE_EN adds port dir (1 = inverse permutation).
module interleaver_mm #(
  parameter int MAX_NCBPS = 288
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
`ifdef WLAN_DEINTERLEAVE_EN
  input  logic       dir,
`endif
  input  logic       in_valid,
  input  logic       in,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out,
  output logic       out_last,
  output logic       mode_err
);

  localparam int AW = (MAX_NCBPS > 1) ? $clog2(MAX_NCBPS) : 1;
  localparam logic [8:0] MAXN = 9'(MAX_NCBPS);

  typedef enum logic {IDLE, READ} state_t;

  state_t               state, state_nxt;
  logic [8:0]           k, ridx;
  logic                 wbank, rbank;
  logic [1:0]           full;
  logic [1:0]           wmode;
  logic                 wdir;
  logic [1:0]           bmode [2];
  logic                 bdir  [2];
  logic [MAX_NCBPS-1:0] mem   [2];

  logic       dir_in;
  logic [1:0] cur_mode;
  logic       cur_dir;
  logic [8:0] cur_n, rd_n;
  logic [8:0] waddr9, raddr9;
  logic       mode_bad, accept, start_bad, wr_en, wr_last, rd_last;

`ifdef WLAN_DEINTERLEAVE_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  function automatic logic [8:0] ncbps(input logic [1:0] m);
    case (m)
      2'd0:    ncbps = 9'd48;
      2'd1:    ncbps = 9'd96;
      2'd2:    ncbps = 9'd192;
      default: ncbps = 9'd288;
    endcase
  endfunction

  // Both permutation steps with constant divisors per mode (no generic divider).
  function automatic logic [8:0] perm(input logic [8:0] kk, input logic [1:0] m);
    logic [9:0] lo, hi, i, t, j;
    lo = {6'd0, kk[3:0]};
    hi = {5'd0, kk[8:4]};
    i  = '0;
    t  = '0;
    j  = '0;
    case (m)
      2'd0: j = 10'd3 * lo + hi;
      2'd1: j = 10'd6 * lo + hi;
      2'd2: begin
        i = 10'd12 * lo + hi;
        t = i + 10'd192 - i / 10'd12;
        j = {i[9:1], 1'b0} + {9'd0, t[0]};
      end
      default: begin
        i = 10'd18 * lo + hi;
        t = i + 10'd288 - i / 10'd18;
        j = 10'd3 * (i / 10'd3) + t % 10'd3;
      end
    endcase
    perm = j[8:0];
  endfunction

  // Mode/dir come straight from the port on the first bit, from the latch afterwards.
  assign cur_mode  = (k == 9'd0) ? mode : wmode;
  assign cur_dir   = (k == 9'd0) ? dir_in : wdir;
  assign cur_n     = ncbps(cur_mode);
  assign mode_bad  = cur_n > MAXN;
  assign rd_n      = ncbps(bmode[rbank]);
  assign rd_last   = (state == READ) && (ridx == rd_n - 9'd1);

  // A bank being drained on its last bit is already free for the next block's first bit.
  assign in_ready  = !full[wbank] || (rd_last && (rbank == wbank));
  assign accept    = in_valid && in_ready;
  assign start_bad = accept && (k == 9'd0) && mode_bad;
  assign wr_en     = accept && !start_bad;
  assign wr_last   = wr_en && (k == cur_n - 9'd1);
  assign waddr9    = cur_dir ? k : perm(k, cur_mode);
  assign raddr9    = bdir[rbank] ? perm(ridx, bmode[rbank]) : ridx;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rbank]) state_nxt = READ;
      READ:    if (rd_last && !full[~rbank]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == READ);
    out       = out_valid && mem[rbank][raddr9[AW-1:0]];
    out_last  = rd_last;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k        <= '0;
      ridx     <= '0;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      full     <= '0;
      mode_err <= 1'b0;
    end else begin
      mode_err <= start_bad;
      if (state == READ) begin
        if (rd_last) begin
          ridx        <= '0;
          rbank       <= ~rbank;
          full[rbank] <= 1'b0;
        end else begin
          ridx <= ridx + 9'd1;
        end
      end
      if (wr_en) begin
        if (wr_last) begin
          k           <= '0;
          wbank       <= ~wbank;
          full[wbank] <= 1'b1;
        end else begin
          k <= k + 9'd1;
        end
      end
    end
  end

  // Bank storage and per-block attributes carry no reset; the full flags gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbank][waddr9[AW-1:0]] <= in;
      if (k == 9'd0) begin
        wmode <= mode;
        wdir  <= dir_in;
      end
      if (wr_last) begin
        bmode[wbank] <= cur_mode;
        bdir[wbank]  <= cur_dir;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_mm.sv
// Randomized bench for interleaver_mm: streams blocks through a 288-bit and a 96-bit instance
// and compares against a reference built from the index formulas.
module tb_interleaver_mm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, din, dir;
  logic [1:0] mode;
  logic       in_ready, out_valid, dout, out_last, mode_err;
  logic       s_in_valid, s_din;
  logic [1:0] s_mode;
  logic       s_in_ready, s_out_valid, s_dout, s_out_last, s_mode_err;

  interleaver_mm #(.MAX_NCBPS(288)) dut (
    .clk(clk), .reset(reset), .mode(mode),
`ifdef WLAN_DEINTERLEAVE_EN
    .dir(dir),
`endif
    .in_valid(in_valid), .in(din), .in_ready(in_ready), .out_valid(out_valid),
    .out(dout), .out_last(out_last), .mode_err(mode_err)
  );

  interleaver_mm #(.MAX_NCBPS(96)) dut_small (
    .clk(clk), .reset(reset), .mode(s_mode),
`ifdef WLAN_DEINTERLEAVE_EN
    .dir(1'b0),
`endif
    .in_valid(s_in_valid), .in(s_din), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out(s_dout), .out_last(s_out_last), .mode_err(s_mode_err)
  );

  typedef struct { logic b; logic last; int cyc; } obs_t;

  obs_t obs_q[$], sobs_q[$], exp_q[$];
  logic blk [288];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   timeouts = 0, stall_cnt = 0, idle_bad = 0, err_pulses = 0, s_err_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t e;
    if (out_valid === 1'b1) begin
      e.b = dout; e.last = out_last; e.cyc = cyc; obs_q.push_back(e);
    end else if (dout !== 1'b0 || out_last !== 1'b0) idle_bad++;
    if (s_out_valid === 1'b1) begin
      e.b = s_dout; e.last = s_out_last; e.cyc = cyc; sobs_q.push_back(e);
    end else if (s_dout !== 1'b0 || s_out_last !== 1'b0) idle_bad++;
    if (mode_err === 1'b1) err_pulses++;
    if (s_mode_err === 1'b1) s_err_pulses++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model, straight from the index formulas.
  function automatic int ncbps_of(input int m);
    return (m == 0) ? 48 : (m == 1) ? 96 : (m == 2) ? 192 : 288;
  endfunction

  function automatic int nbpsc_of(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
  endfunction

  function automatic int jmap(input int kk, input int n, input int nb);
    int s, i;
    s = (nb / 2 > 1) ? nb / 2 : 1;
    i = (n / 16) * (kk % 16) + kk / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  task automatic model_block(input int m, input bit d);
    int   n = ncbps_of(m);
    int   nb = nbpsc_of(m);
    logic o [288];
    obs_t e;
    for (int kk = 0; kk < n; kk++) begin
      if (!d) o[jmap(kk, n, nb)] = blk[kk];
      else    o[kk] = blk[jmap(kk, n, nb)];
    end
    for (int r = 0; r < n; r++) begin
      e.b = o[r]; e.last = (r == n - 1); e.cyc = 0; exp_q.push_back(e);
    end
  endtask

  function automatic int mism(input bit sel);
    int e = 0;
    int sz = sel ? sobs_q.size() : obs_q.size();
    for (int r = 0; r < exp_q.size(); r++) begin
      if (r >= sz) e++;
      else if (!sel && (obs_q[r].b !== exp_q[r].b || obs_q[r].last !== exp_q[r].last)) e++;
      else if (sel && (sobs_q[r].b !== exp_q[r].b || sobs_q[r].last !== exp_q[r].last)) e++;
    end
    return e;
  endfunction

  function automatic int gaps(input int first, input int n);
    int g = 0;
    for (int r = first + 1; r < first + n && r < obs_q.size(); r++)
      if (obs_q[r].cyc != obs_q[r-1].cyc + 1) g++;
    return g;
  endfunction

  task automatic randomize_blk();
    for (int kk = 0; kk < 288; kk++) blk[kk] = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the bit was taken.
  task automatic drive_bit(input bit sel, input logic b, input logic [1:0] m, input bit d, output int acc);
    int guard = 0;
    if (!sel) begin
      mode = m; din = b; dir = d; in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 3000) begin stall_cnt++; @(negedge clk); guard++; end
    end else begin
      s_mode = m; s_din = b; s_in_valid = 1'b1;
      while (s_in_ready !== 1'b1 && guard < 3000) begin stall_cnt++; @(negedge clk); guard++; end
    end
    if (guard >= 3000) timeouts++;
    acc = cyc + 1;
    @(negedge clk);
    if (!sel) in_valid = 1'b0; else s_in_valid = 1'b0;
  endtask

  // Mode and dir are randomised after the first bit; the DUT must ignore them.
  task automatic send_block(input bit sel, input int m, input bit d, input int nbits,
                            input int gap_pct, output int last_acc);
    int acc = 0;
    for (int kk = 0; kk < nbits; kk++) begin
      drive_bit(sel, blk[kk], (kk == 0) ? 2'(m) : 2'($urandom), (kk == 0) ? d : 1'($urandom), acc);
      if ($urandom_range(99) < gap_pct) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    last_acc = acc;
  endtask

  task automatic wait_drain(input bit sel, input int n);
    int g = 0;
    while ((sel ? sobs_q.size() : obs_q.size()) < n && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) timeouts++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", dout); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL reset_mode_err: got %b want 0", mode_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_bit();
    int hi_tab [4] = '{3, 6, 13, 20};
    int acc, n, hcnt, hidx, first;
    for (int m = 0; m < 4; m++) begin
      n = ncbps_of(m);
      for (int kk = 0; kk < 288; kk++) blk[kk] = 1'b0;
      blk[1] = 1'b1;
      obs_q.delete(); exp_q.delete();
      send_block(0, m, 0, n, 0, acc);
      model_block(m, 0);
      wait_drain(0, n);
      first = (obs_q.size() > 0) ? obs_q[0].cyc : -1;
      hcnt = 0; hidx = -1;
      foreach (obs_q[r]) if (obs_q[r].b === 1'b1) begin hcnt++; hidx = r; end
      checks++; if (obs_q.size() != n) begin errors++; $display("FAIL single_count m=%0d: got %0d want %0d", m, obs_q.size(), n); end
      checks++; if (mism(0) != 0) begin errors++; $display("FAIL single_data m=%0d: %0d bad bits, want 0", m, mism(0)); end
      checks++; if (hcnt != 1 || hidx != hi_tab[m]) begin errors++; $display("FAIL single_high_idx m=%0d: got idx %0d (%0d highs) want idx %0d", m, hidx, hcnt, hi_tab[m]); end
      checks++; if (first != acc + 1) begin errors++; $display("FAIL single_latency m=%0d: first out cycle %0d want %0d", m, first, acc + 1); end
      checks++; if (gaps(0, n) != 0) begin errors++; $display("FAIL single_stream m=%0d: %0d bubbles want 0", m, gaps(0, n)); end
    end
  endtask

  task automatic test_random_gaps();
    int acc, total = 0, m;
    obs_q.delete(); exp_q.delete();
    for (int b = 0; b < 6; b++) begin
      m = $urandom_range(3);
      randomize_blk();
      send_block(0, m, 0, ncbps_of(m), 30, acc);
      model_block(m, 0);
      total += ncbps_of(m);
    end
    wait_drain(0, total);
    checks++; if (obs_q.size() != total) begin errors++; $display("FAIL gaps_count: got %0d want %0d", obs_q.size(), total); end
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL gaps_data: %0d bad bits, want 0", mism(0)); end
  endtask

  task automatic test_back_to_back();
    int acc;
    obs_q.delete(); exp_q.delete();
    stall_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      randomize_blk();
      send_block(0, 3, 0, 288, 0, acc);
      model_block(3, 0);
    end
    wait_drain(0, 864);
    checks++; if (stall_cnt != 0) begin errors++; $display("FAIL b2b_in_ready: %0d stall cycles want 0", stall_cnt); end
    checks++; if (obs_q.size() != 864) begin errors++; $display("FAIL b2b_count: got %0d want 864", obs_q.size()); end
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL b2b_data: %0d bad bits, want 0", mism(0)); end
    checks++; if (gaps(0, 864) != 0) begin errors++; $display("FAIL b2b_stream: %0d bubbles want 0", gaps(0, 864)); end
  endtask

  task automatic test_mode_mix();
    int acc, g = 0, r1 = -1, lc = -1;
    logic rdy_after;
    obs_q.delete(); exp_q.delete();
    randomize_blk(); send_block(0, 3, 0, 288, 0, acc); model_block(3, 0);
    randomize_blk(); send_block(0, 0, 0, 48, 0, acc);  model_block(0, 0);
    rdy_after = in_ready;
    while (in_ready !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) timeouts++;
    r1 = cyc;
    wait_drain(0, 336);
    if (obs_q.size() > 288) lc = obs_q[287].last ? obs_q[287].cyc : -2;
    checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL mix_ready_low: got %b want 0", rdy_after); end
    checks++; if (r1 != lc) begin errors++; $display("FAIL mix_ready_release: in_ready high at cycle %0d want %0d", r1, lc); end
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL mix_data: %0d bad bits, want 0", mism(0)); end
    checks++; if (gaps(0, 336) != 0) begin errors++; $display("FAIL mix_stream: %0d bubbles want 0", gaps(0, 336)); end
  endtask

  task automatic test_reset_mid();
    int acc;
    randomize_blk(); send_block(0, 2, 0, 192, 0, acc);
    randomize_blk(); send_block(0, 3, 0, 100, 0, acc);
    in_valid = 1'b1; din = blk[100]; reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || dout !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL midrst_outputs: valid/out/last %b%b%b want 000", out_valid, dout, out_last); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL midrst_mode_err: got %b want 0", mode_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    obs_q.delete(); exp_q.delete();
    randomize_blk(); send_block(0, 1, 0, 96, 10, acc); model_block(1, 0);
    wait_drain(0, 96);
    repeat (300) @(negedge clk);
    checks++; if (obs_q.size() != 96) begin errors++; $display("FAIL midrst_count: got %0d want 96", obs_q.size()); end
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL midrst_data: %0d bad bits, want 0", mism(0)); end
  endtask

  task automatic test_mode_err();
    int acc;
    logic rdy, e1, e2;
    sobs_q.delete(); exp_q.delete();
    s_mode = 2'd3; s_din = 1'b1; s_in_valid = 1'b1;
    rdy = s_in_ready;
    @(negedge clk);
    e1 = s_mode_err; s_in_valid = 1'b0;
    @(negedge clk);
    e2 = s_mode_err;
    repeat (300) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL err_in_ready: got %b want 1", rdy); end
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", e1); end
    checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", e2); end
    checks++; if (s_err_pulses != 1) begin errors++; $display("FAIL err_pulse_width: got %0d cycles want 1", s_err_pulses); end
    checks++; if (sobs_q.size() != 0) begin errors++; $display("FAIL err_no_output: got %0d bits want 0", sobs_q.size()); end
    randomize_blk(); send_block(1, 0, 0, 48, 20, acc); model_block(0, 0);
    wait_drain(1, 48);
    checks++; if (sobs_q.size() != 48) begin errors++; $display("FAIL err_recover_count: got %0d want 48", sobs_q.size()); end
    checks++; if (mism(1) != 0) begin errors++; $display("FAIL err_recover_data: %0d bad bits, want 0", mism(1)); end
  endtask

`ifdef WLAN_DEINTERLEAVE_EN
  task automatic test_deinterleave();
    int   acc;
    logic orig [288];
    obs_t e;
    obs_q.delete(); exp_q.delete();
    randomize_blk();
    foreach (orig[kk]) orig[kk] = blk[kk];
    send_block(0, 3, 0, 288, 0, acc); model_block(3, 0);
    wait_drain(0, 288);
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL deint_fwd_data: %0d bad bits, want 0", mism(0)); end
    for (int kk = 0; kk < 288; kk++) blk[kk] = (kk < obs_q.size()) ? obs_q[kk].b : 1'b0;
    obs_q.delete(); exp_q.delete();
    for (int kk = 0; kk < 288; kk++) begin
      e.b = orig[kk]; e.last = (kk == 287); e.cyc = 0; exp_q.push_back(e);
    end
    send_block(0, 3, 1, 288, 15, acc);
    wait_drain(0, 288);
    checks++; if (mism(0) != 0) begin errors++; $display("FAIL deint_restore: %0d bad bits, want 0", mism(0)); end
  endtask
`endif

  task automatic test_quiet();
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_outputs: %0d cycles with out/out_last set while invalid, want 0", idle_bad); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL main_mode_err: %0d pulses want 0", err_pulses); end
    checks++; if (timeouts != 0) begin errors++; $display("FAIL timeouts: %0d expired waits want 0", timeouts); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; din = 1'b0; mode = 2'd0; dir = 1'b0;
    s_in_valid = 1'b0; s_din = 1'b0; s_mode = 2'd0;
    test_reset();
    test_single_bit();
    test_random_gaps();
    test_back_to_back();
    test_mode_mix();
    test_reset_mid();
    test_mode_err();
`ifdef WLAN_DEINTERLEAVE_EN
    test_deinterleave();
`endif
    test_quiet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
